multicycle_control_unit: RTL
============================

# multicycle_control_unit

Parametrised multi-cycle controller for the small 4-op ALU datapath: it fetches an opcode over a valid/ready handshake, latches it in an internal instruction register, and sequences DECODE, EXECUTE and WRITEBACK over several clocks. It also resolves branches from the ALU zero flag, traps illegal opcodes and counts retired instructions. It sits between the instruction source and the register file / ALU / PC logic of the core.

## Interface
Parameters:
- OPCODE_W, 4, opcode width, >= 4; bits above [3:0] must be zero for a legal opcode
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_valid  in  1  opcode on `opcode` is valid
- opcode  in  OPCODE_W  instruction opcode
- instr_ready  out  1  controller accepts an opcode this cycle
- alu_zero  in  1  ALU zero flag, sampled in EXECUTE of a branch
- alu_src  out  1  0 = register operand, 1 = immediate
- alu_control  out  2  ALU operation select
- reg_write  out  1  register file write strobe
- pc_en  out  1  PC update strobe
- pc_src  out  1  0 = PC+1, 1 = branch target; meaningful only with pc_en
- halted  out  1  trap state reached (sticky until reset)
- retired  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE:
  - entered on reset
  - always goes to FETCH next cycle
- FETCH:
  - instr_ready=1
  - on instr_valid && instr_ready, latch opcode into IR and go to DECODE
  - otherwise stay in FETCH
- DECODE:
  - 0000-0011 (reg ALU) and 0100-0110 (imm ALU) go to EXECUTE
  - 0111 (branch) goes to EXECUTE
  - 1000 (NOP): pc_en=1, pc_src=0, retired+1, go to FETCH
  - any other value, or nonzero upper bits, goes to HALT
- EXECUTE:
  - alu_control = IR[1:0] for ALU ops and 2'b11 for branch
  - alu_src=1 only for 0100-0110
  - ALU ops go to WRITEBACK
  - branch: pc_en=1, pc_src=alu_zero, retired+1, go to FETCH
- WRITEBACK:
  - reg_write=1, pc_en=1, pc_src=0
  - alu_src/alu_control held at EXECUTE values
  - retired+1, go to FETCH
- HALT: all strobes 0, instr_ready=0, halted=1; exits only via reset.
- Strobe outputs are decoded from registered state and IR; each strobe is high for exactly one cycle per instruction.
- retired wraps modulo 2^CNT_W with no saturation or flag.

## Timing
- Reset (rst_n low at a clock edge):
  - state=IDLE, IR=0, retired=0
  - all outputs 0, including instr_ready and halted
- Reset mid-instruction aborts it: no strobe fires in the cycle after reset, and the count is not incremented.
- First instr_ready=1 appears 2 cycles after rst_n is sampled high (IDLE, then FETCH).
- ALU op: handshake at cycle T, DECODE T+1, EXECUTE T+2, reg_write/pc_en at T+3, instr_ready again at T+4.
- Branch: pc_en at T+2, instr_ready at T+3.
- NOP: pc_en at T+1, instr_ready at T+2.
- Illegal: halted=1 from T+2 onward.
- alu_zero is sampled only in the branch EXECUTE cycle; its value in any other cycle is ignored.
- instr_valid asserted outside FETCH is ignored; the source must hold opcode and instr_valid until it sees instr_ready.

## Structure
- Package ctrl_pkg holds:
  - state_t enum
  - opcode localparams (OP_ADD..OP_AND_R, OP_ADDI..OP_ORI, OP_BEQ, OP_NOP)
  - alu_ctrl_t (2-bit)
- Sub-module control_decode: combinational, IR maps to {is_alu, is_imm, is_branch, is_nop, is_illegal, alu_control}.
- The FSM, IR and counter live in the top module.

## Test plan
- Reset then idle: hold rst_n low 3 cycles, then release with instr_valid=0. Required: all outputs 0 in the reset cycles; instr_ready=1 from the 2nd cycle after release; retired=0.
- Opcode 0101 accepted at T: alu_src=1 and alu_control=01 at T+2 and T+3; reg_write=pc_en=1 only at T+3; retired=1.
- Opcode 0111 twice, first with alu_zero=1 then with alu_zero=0: pc_src=1 then pc_src=0 with pc_en in EXECUTE; reg_write never 1; retired=2.
- Opcode 1000 then 1111: the NOP pulses pc_en at T+1; then halted=1 and instr_ready=0 permanently with instr_valid held high; retired stays 1 until rst_n low.
- Stalled handshake plus mid-run reset: instr_valid low 5 cycles in FETCH causes no state change; then assert rst_n low during EXECUTE of opcode 0010. Required: no reg_write pulse, retired=0.
- Counter wrap with CNT_W=4: 16 back-to-back opcode 0000 instructions leave retired=0; 17 leave retired=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and opcode encodings for the multi-cycle controller and its decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    typedef logic [1:0] alu_ctrl_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_OR_R  = 4'b0010;
    localparam logic [3:0] OP_AND_R = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_SUBI  = 4'b0101;
    localparam logic [3:0] OP_ORI   = 4'b0110;
    localparam logic [3:0] OP_BEQ   = 4'b0111;
    localparam logic [3:0] OP_NOP   = 4'b1000;

    localparam alu_ctrl_t ALU_BRANCH = 2'b11;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: maps the instruction register to class flags and ALU select.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] ir,
    output logic                is_alu,
    output logic                is_imm,
    output logic                is_branch,
    output logic                is_nop,
    output logic                is_illegal,
    output alu_ctrl_t           alu_control
);

    logic [3:0] op;
    assign op = ir[3:0];

    // Legal opcodes are exactly 0..OP_NOP, so any set upper bit also lands here.
    assign is_illegal  = ir > OPCODE_W'(OP_NOP);
    assign is_alu      = !is_illegal && (op <= OP_ORI);
    assign is_imm      = !is_illegal && (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_branch   = !is_illegal && (op == OP_BEQ);
    assign is_nop      = !is_illegal && (op == OP_NOP);
    assign alu_control = is_branch ? ALU_BRANCH : op[1:0];

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller: fetch handshake, IR, DECODE/EXECUTE/WRITEBACK sequencing,
// branch resolution, illegal-opcode trap and retired-instruction counter.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                instr_ready,
    input  logic                alu_zero,
    output logic                alu_src,
    output logic [1:0]          alu_control,
    output logic                reg_write,
    output logic                pc_en,
    output logic                pc_src,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    state_t              state, state_nxt;
    logic [OPCODE_W-1:0] ir;
    logic [CNT_W-1:0]    cnt;

    logic      is_alu, is_imm, is_branch, is_nop, is_illegal;
    alu_ctrl_t dec_ctrl;

    control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .ir          (ir),
        .is_alu      (is_alu),
        .is_imm      (is_imm),
        .is_branch   (is_branch),
        .is_nop      (is_nop),
        .is_illegal  (is_illegal),
        .alu_control (dec_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                          ir <= '0;
        else if (state == FETCH && instr_valid) ir <= opcode;
    end

    // pc_en fires exactly once per completed instruction, so it doubles as the retire strobe.
    always_ff @(posedge clk) begin
        if (!rst_n)     cnt <= '0;
        else if (pc_en) cnt <= cnt + CNT_W'(1);
    end

    assign retired = cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = FETCH;
            FETCH:     if (instr_valid) state_nxt = DECODE;
            DECODE: begin
                if (is_illegal)                state_nxt = HALT;
                else if (is_nop)               state_nxt = FETCH;
                else if (is_alu || is_branch)  state_nxt = EXECUTE;
                else                           state_nxt = HALT;
            end
            EXECUTE:   state_nxt = is_branch ? FETCH : WRITEBACK;
            WRITEBACK: state_nxt = FETCH;
            HALT:      state_nxt = HALT;
            default:   state_nxt = IDLE;
        endcase
    end

    // EXECUTE is only reached by ALU ops and branches; the decoder already yields 2'b11 and
    // is_imm=0 for a branch, so both states can take the decoder outputs directly.
    always_comb begin
        instr_ready = 1'b0;
        alu_src     = 1'b0;
        alu_control = 2'b00;
        reg_write   = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH:  instr_ready = 1'b1;
            DECODE: pc_en       = is_nop;
            EXECUTE: begin
                alu_src     = is_imm;
                alu_control = dec_ctrl;
                if (is_branch) begin
                    pc_en  = 1'b1;
                    pc_src = alu_zero;
                end
            end
            WRITEBACK: begin
                alu_src     = is_imm;
                alu_control = dec_ctrl;
                reg_write   = 1'b1;
                pc_en       = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule
